// File: rtl/sar_search.sv
// Successive-approximation search engine: drives a trial value into an external
// magnitude comparator and resolves the comparator's other operand MSB first.
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             alb,
    input  logic             aeb,
    input  logic             agb,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);

    typedef enum logic {
        IDLE,
        PROBE
    } state_t;

    state_t           state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] kept;
    logic [WIDTH-1:0] next_trial;
    logic             one_hot;

    // The bit under test is dropped when the trial overshoots; the next lower
    // bit is then tentatively set for the following probe.
    always_comb begin
        bit_mask   = ONE << k;
        kept       = agb ? (trial & ~bit_mask) : trial;
        next_trial = kept | (bit_mask >> 1);
        one_hot    = ( alb & ~aeb & ~agb) |
                     (~alb &  aeb & ~agb) |
                     (~alb & ~aeb &  agb);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            k      <= '0;
            trial  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    trial <= '0;
                    if (start) begin
                        state  <= PROBE;
                        trial  <= MSB;
                        k      <= KW'(WIDTH - 1);
                        busy   <= 1'b1;
                        result <= '0;
                        found  <= 1'b0;
                        err    <= 1'b0;
                    end
                end
                PROBE: begin
                    // Corrupt flags abort immediately and outrank an exact match.
                    if (!one_hot) begin
                        state  <= IDLE;
                        trial  <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= '0;
                        found  <= 1'b0;
                        err    <= 1'b1;
                    end else if (aeb) begin
                        state  <= IDLE;
                        trial  <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= trial;
                        found  <= 1'b1;
                    end else if (k == '0) begin
                        state  <= IDLE;
                        trial  <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= kept;
                        found  <= 1'b0;
                    end else begin
                        trial <= next_trial;
                        k     <= k - KW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    trial <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
